// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter and access sequencer for a two-requester, single-port synchronous SRAM.
// Each transaction runs ACCESS -> CAPTURE -> ACK and then returns to IDLE.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              rw_bar_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              req_b,
  input  logic              rw_bar_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_a,
  output logic [DATA_W-1:0] rdata_a,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              mem_cs,
  output logic              mem_rw_bar,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;

  state_t              state, state_nxt;
  logic                last_b, last_b_nxt;
  logic                pick_b;
  logic                mem_cs_nxt, mem_rw_bar_nxt;
  logic [ADDR_W-1:0]   mem_addr_nxt;
  logic [DATA_W-1:0]   mem_wdata_nxt;
  logic                ack_a_nxt, ack_b_nxt, busy_nxt;
  logic [DATA_W-1:0]   rdata_a_nxt, rdata_b_nxt;

  // State and all registered outputs; last_b doubles as the current winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_b     <= 1'b1;
      mem_cs     <= 1'b0;
      mem_rw_bar <= 1'b1;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      rdata_a    <= '0;
      rdata_b    <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_b     <= last_b_nxt;
      mem_cs     <= mem_cs_nxt;
      mem_rw_bar <= mem_rw_bar_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      ack_a      <= ack_a_nxt;
      ack_b      <= ack_b_nxt;
      rdata_a    <= rdata_a_nxt;
      rdata_b    <= rdata_b_nxt;
      busy       <= busy_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt      = state;
    last_b_nxt     = last_b;
    pick_b         = 1'b0;
    mem_cs_nxt     = 1'b0;
    mem_rw_bar_nxt = mem_rw_bar;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    ack_a_nxt      = 1'b0;
    ack_b_nxt      = 1'b0;
    rdata_a_nxt    = rdata_a;
    rdata_b_nxt    = rdata_b;

    case (state)
      IDLE: begin
        if (req_a || req_b) begin
          // On a tie, B wins only if A was granted last.
          pick_b         = req_b && (!req_a || !last_b);
          last_b_nxt     = pick_b;
          mem_cs_nxt     = 1'b1;
          mem_rw_bar_nxt = pick_b ? rw_bar_b : rw_bar_a;
          mem_addr_nxt   = pick_b ? addr_b   : addr_a;
          mem_wdata_nxt  = pick_b ? wdata_b  : wdata_a;
          state_nxt      = ACCESS;
        end
      end
      ACCESS: begin
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (mem_rw_bar) begin
          if (last_b) rdata_b_nxt = mem_rdata;
          else        rdata_a_nxt = mem_rdata;
        end
        ack_a_nxt = !last_b;
        ack_b_nxt = last_b;
        state_nxt = ACK;
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule
